// File: rtl/match_engine_job_sequencer.sv
// match_engine_job_sequencer: gates one compression job at a time into the hash/sync path and checks its delim
module match_engine_job_sequencer #(
  parameter int HASH_ISSUE_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH = 24
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            job_valid,
  input  logic [LEN_WIDTH-1:0]            job_beats,
  output logic                            job_ready,
  input  logic                            src_valid,
  input  logic [HASH_ISSUE_WIDTH*8-1:0]   src_data,
  output logic                            src_ready,
  output logic                            dst_valid,
  output logic [HASH_ISSUE_WIDTH*8-1:0]   dst_data,
  output logic                            dst_last,
  input  logic                            dst_ready,
  input  logic                            sync_fire,
  input  logic                            sync_delim,
  output logic                            done_valid,
  output logic [ADDR_WIDTH-1:0]           done_start_addr,
  output logic [LEN_WIDTH-1:0]            done_beats,
  input  logic                            done_ready,
  output logic                            err,
  output logic                            busy
);
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DELIM, REPORT} state_t;
  state_t state, state_nxt;
  logic [LEN_WIDTH-1:0] len, len_m1, issue_cnt, mon_cnt;
  logic [ADDR_WIDTH-1:0] issue_addr, start_addr;
  logic streaming, active, reporting, job_fire, dst_fire, delim_fire, err_set;
  assign streaming  = state == STREAM;
  assign active     = streaming || state == WAIT_DELIM;
  assign reporting  = state == REPORT;
  assign len_m1     = len - LEN_WIDTH'(1);
  assign job_ready  = state == IDLE;
  assign job_fire   = job_valid && job_ready;
  assign src_ready  = streaming && dst_ready;
  assign dst_valid  = streaming && src_valid;
  assign dst_data   = src_data;
  assign dst_last   = streaming && len != '0 && issue_cnt == len_m1;
  assign dst_fire   = dst_valid && dst_ready;
  assign delim_fire = active && sync_fire && sync_delim;
  assign done_valid      = reporting;
  assign done_start_addr = reporting ? start_addr : '0;
  assign done_beats      = reporting ? len : '0;
  assign busy            = state != IDLE;
  // Outside STREAM/WAIT_DELIM len may be 0, but any sync beat there is already an error
  assign err_set = sync_fire && (!active || mon_cnt >= issue_cnt ||
                   (sync_delim ? mon_cnt != len_m1 : mon_cnt == len_m1));
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (job_valid) state_nxt = (job_beats != '0) ? STREAM : REPORT;
      STREAM:     state_nxt = delim_fire ? REPORT : (dst_fire && dst_last) ? WAIT_DELIM : STREAM;
      WAIT_DELIM: if (delim_fire) state_nxt = REPORT;
      REPORT:     if (done_ready) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      start_addr <= '0;
      issue_addr <= '0;
      issue_cnt  <= '0;
      mon_cnt    <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (job_fire) begin
        len        <= job_beats;
        start_addr <= issue_addr;
        issue_cnt  <= '0;
        mon_cnt    <= '0;
      end
      if (dst_fire) begin
        issue_cnt  <= issue_cnt + LEN_WIDTH'(1);
        issue_addr <= issue_addr + ADDR_WIDTH'(HASH_ISSUE_WIDTH);
      end
      if (active && sync_fire) mon_cnt <= mon_cnt + LEN_WIDTH'(1);
      if (err_set) err <= 1'b1;
    end
  end
endmodule
